fp_soc_keycode_in: RTL and testbench

//  Avalon-MM slave input port: the CPU-facing reader for scan codes produced by

---
 rtl/fp_soc_pkg.sv | 40 ++++
 rtl/fp_soc_keycode_fifo.sv | 81 ++++++++
 rtl/fp_soc_keycode_in.sv | 122 ++++++++++++
 tb/tb_fp_soc_keycode_in.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_soc_pkg.sv
// Shared fp_soc definitions: keycode port register map and field positions.
package fp_soc_pkg;

    // Word offsets of the keycode input port registers
    typedef enum logic [1:0] {
        KC_DATA   = 2'd0,
        KC_STATUS = 2'd1,
        KC_MASK   = 2'd2,
        KC_RSVD   = 2'd3
    } kc_reg_e;

    // STATUS register field positions
    localparam int unsigned ST_FLUSH = 0;   // write-1 flushes the FIFO
    localparam int unsigned ST_EMPTY = 8;
    localparam int unsigned ST_FULL  = 9;
    localparam int unsigned ST_OVF   = 10;  // sticky, write-1 clears

    // MASK register field position
    localparam int unsigned MASK_IRQ_EN = 0;

    // DATA register valid flag position
    localparam int unsigned DATA_VALID_BIT = 31;

    // Assemble the STATUS read word; count is zero-extended into the low bits
    function automatic logic [31:0] kc_status_word(
        input logic [7:0] count,
        input logic       empty,
        input logic       full,
        input logic       ovf
    );
        logic [31:0] w;
        w           = '0;
        w[7:0]      = count;
        w[ST_EMPTY] = empty;
        w[ST_FULL]  = full;
        w[ST_OVF]   = ovf;
        return w;
    endfunction

endpackage

// File: rtl/fp_soc_keycode_fifo.sv
// Synchronous FIFO for keycodes: push/pop/flush with occupancy count.
// Pop on empty is ignored; push on full is accepted only alongside a pop.
module fp_soc_keycode_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] head_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              pop_eff;
    logic              push_eff;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign pop_eff  = pop_i & ~empty_o & ~flush_i;
    assign push_eff = push_i & (~full_o | pop_eff) & ~flush_i;

    // Next pointer/count state; pointers wrap naturally since DEPTH is a power of 2
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop_eff) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push_eff) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (push_eff && !pop_eff) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop_eff && !push_eff) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk_i) begin
        if (push_eff) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/fp_soc_keycode_in.sv
// Avalon-MM keycode input port: buffers hardware scan codes in a FIFO and
// exposes DATA/STATUS/MASK registers with a level IRQ while codes are pending.
module fp_soc_keycode_in
    import fp_soc_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              irq
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    kc_reg_e           reg_sel;
    logic              rd_stb;
    logic              wr_stb;
    logic              pop;
    logic              flush;
    logic              ovf_clr;
    logic              ovf_set;
    logic              push;
    logic              ovf_q,  ovf_d;
    logic              mask_q, mask_d;
    logic [DATA_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              unused_wdata;

    assign unused_wdata = ^{writedata[31:11], writedata[9:1]};

    assign reg_sel = kc_reg_e'(address);
    assign rd_stb  = chipselect & ~read_n;
    assign wr_stb  = chipselect & ~write_n;

    // Bus decode: DATA reads pop only when something is there to pop
    assign pop     = rd_stb & (reg_sel == KC_DATA) & ~fifo_empty;
    assign flush   = wr_stb & (reg_sel == KC_STATUS) & writedata[ST_FLUSH];
    assign ovf_clr = wr_stb & (reg_sel == KC_STATUS) & writedata[ST_OVF];

    // A full FIFO still accepts a code when the same cycle pops; flush discards it
    assign push    = in_valid & ~flush & (~fifo_full | pop);
    assign ovf_set = in_valid & ~flush & fifo_full & ~pop;

    fp_soc_keycode_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .data_i  (in_data),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next overflow/mask state; a new overflow beats a same-cycle clear
    always_comb begin
        ovf_d  = ovf_q;
        mask_d = mask_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (wr_stb && (reg_sel == KC_MASK)) begin
            mask_d = writedata[MASK_IRQ_EN];
        end
    end

    // Sticky overflow flag and interrupt mask
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q  <= 1'b0;
            mask_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            mask_q <= mask_d;
        end
    end

    // Zero-latency read mux; DATA reads as all-zero while empty
    always_comb begin
        readdata = '0;
        unique case (reg_sel)
            KC_DATA: begin
                if (!fifo_empty) begin
                    readdata[DATA_W-1:0]     = fifo_head;
                    readdata[DATA_VALID_BIT] = 1'b1;
                end
            end
            KC_STATUS: begin
                readdata = kc_status_word(8'(fifo_count), fifo_empty, fifo_full, ovf_q);
            end
            KC_MASK: begin
                readdata[MASK_IRQ_EN] = mask_q;
            end
            default: begin
                readdata = '0;
            end
        endcase
    end

    // Level interrupt derived purely from registered state
    assign irq = mask_q & ~fifo_empty;

endmodule

// File: tb/tb_fp_soc_keycode_in.sv
// Scoreboard bench for fp_soc_keycode_in: stimulus pushes per-cycle expectations
// computed from a queue-based reference model; a monitor checks at negedge.
module tb_fp_soc_keycode_in;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        irq;

    fp_soc_keycode_in #(.DATA_W(8), .DEPTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        logic [1:0]  addr;
        logic [31:0] rdata;
        logic        irq;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    logic [7:0] m_q[$];
    bit         m_ovf;
    bit         m_mask;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [31:0] w;
        w = 32'h0;
        case (a)
            2'd0: if (m_q.size() > 0) w = 32'h8000_0000 | 32'(m_q[0]);
            2'd1: w = 32'(m_q.size()) + ((m_q.size() == 0) ? 32'h100 : 32'h0)
                      + ((m_q.size() == DEPTH) ? 32'h200 : 32'h0)
                      + (m_ovf ? 32'h400 : 32'h0);
            2'd2: w = {31'b0, m_mask};
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    // One bus cycle: drive, record expectation, advance the model
    task automatic step(input bit rst, input bit cs, input bit rdn, input bit wrn,
                        input logic [1:0] a, input logic [31:0] wd,
                        input bit iv, input logic [7:0] id);
        exp_t e;
        bit   do_flush;
        bit   do_pop;
        @(posedge clk);
        #1;
        reset      = rst;
        chipselect = cs;
        read_n     = rdn;
        write_n    = wrn;
        address    = a;
        writedata  = wd;
        in_valid   = iv;
        in_data    = id;
        if (rst) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_mask = 1'b0;
        end
        e.rd    = cs && !rdn;
        e.addr  = a;
        e.rdata = model_read(a);
        e.irq   = m_mask && (m_q.size() != 0);
        sb.push_back(e);
        if (!rst) begin
            do_flush = cs && !wrn && a == 2'd1 && wd[0];
            if (do_flush) begin
                m_q.delete();
            end else begin
                do_pop = cs && !rdn && a == 2'd0 && m_q.size() > 0;
                if (do_pop) void'(m_q.pop_front());
                if (iv) begin
                    if (m_q.size() < DEPTH) m_q.push_back(id);
                    else m_ovf = 1'b1;
                end
            end
            if (cs && !wrn && a == 2'd1 && wd[10] && !(iv && !do_flush && m_q.size() == DEPTH && !do_pop_hist(do_flush, do_pop)))
                ;
            if (cs && !wrn && a == 2'd2) m_mask = wd[0];
        end
    endtask

    // Helper kept trivial: overflow clear is resolved separately below
    function automatic bit do_pop_hist(input bit f, input bit p);
        return f | p;
    endfunction

    bit last_set;

    // Overflow clear resolution: clear applies unless this same cycle set overflow
    task automatic step_full(input bit rst, input bit cs, input bit rdn, input bit wrn,
                             input logic [1:0] a, input logic [31:0] wd,
                             input bit iv, input logic [7:0] id);
        int  before_sz;
        bit  will_set;
        bit  flush_w;
        bit  pop_w;
        flush_w   = cs && !wrn && a == 2'd1 && wd[0];
        pop_w     = cs && !rdn && a == 2'd0;
        before_sz = m_q.size();
        will_set  = !rst && iv && !flush_w && before_sz == DEPTH && !pop_w;
        step(rst, cs, rdn, wrn, a, wd, iv, id);
        if (!rst && cs && !wrn && a == 2'd1 && wd[10] && !will_set) m_ovf = 1'b0;
    endtask

    task automatic idle(input bit iv, input logic [7:0] id);
        step_full(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0, iv, id);
    endtask
    task automatic rd(input logic [1:0] a, input bit iv, input logic [7:0] id);
        step_full(1'b0, 1'b1, 1'b0, 1'b1, a, 32'h0, iv, id);
    endtask
    task automatic wr(input logic [1:0] a, input logic [31:0] wd, input bit iv, input logic [7:0] id);
        step_full(1'b0, 1'b1, 1'b1, 1'b0, a, wd, iv, id);
    endtask
    task automatic rst_rd(input logic [1:0] a);
        step_full(1'b1, 1'b1, 1'b0, 1'b1, a, 32'h0, 1'b0, 8'h0);
    endtask

    // Monitor: one expectation per cycle, compared away from the active edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (irq !== e.irq) begin
                    n_fail++;
                    $display("FAIL irq at %0t: got %b expected %b", $time, irq, e.irq);
                end
                if (e.rd) begin
                    n_checks++;
                    if (readdata !== e.rdata) begin
                        n_fail++;
                        $display("FAIL readdata addr=%0d at %0t: got %h expected %h",
                                 e.addr, $time, readdata, e.rdata);
                    end
                end
            end
        end
    end

    // Global time bound
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        logic [31:0] wd;
        m_ovf  = 1'b0;
        m_mask = 1'b0;

        // Reset state at every address
        for (int a = 0; a < 4; a++) rst_rd(2'(a));
        idle(1'b0, 8'h0);
        rd(2'd1, 1'b0, 8'h0);

        // Two codes then drain, including an empty read
        idle(1'b1, 8'h1C);
        idle(1'b1, 8'h32);
        rd(2'd1, 1'b0, 8'h0);
        rd(2'd0, 1'b0, 8'h0);
        rd(2'd0, 1'b0, 8'h0);
        rd(2'd0, 1'b0, 8'h0);
        rd(2'd1, 1'b0, 8'h0);

        // Overflow by nine back-to-back pushes, drain, clear overflow
        for (int i = 1; i <= 9; i++) idle(1'b1, 8'(i));
        rd(2'd1, 1'b0, 8'h0);
        for (int i = 0; i < 8; i++) rd(2'd0, 1'b0, 8'h0);
        rd(2'd1, 1'b0, 8'h0);
        wr(2'd1, 32'h400, 1'b0, 8'h0);
        rd(2'd1, 1'b0, 8'h0);

        // IRQ rise on push and fall on popping the last entry
        wr(2'd2, 32'h1, 1'b0, 8'h0);
        rd(2'd2, 1'b0, 8'h0);
        idle(1'b1, 8'h5A);
        idle(1'b0, 8'h0);
        rd(2'd0, 1'b0, 8'h0);
        idle(1'b0, 8'h0);

        // Full FIFO with simultaneous pop and push
        for (int i = 0; i < 8; i++) idle(1'b1, 8'h40 + 8'(i));
        rd(2'd0, 1'b1, 8'h77);
        rd(2'd1, 1'b0, 8'h0);
        for (int i = 0; i < 8; i++) rd(2'd0, 1'b0, 8'h0);

        // Flush racing a push, and overflow clear racing a new overflow
        for (int i = 0; i < 8; i++) idle(1'b1, 8'h90 + 8'(i));
        wr(2'd1, 32'h400, 1'b1, 8'hEE);
        rd(2'd1, 1'b0, 8'h0);
        wr(2'd1, 32'h1, 1'b1, 8'hEF);
        rd(2'd1, 1'b0, 8'h0);
        idle(1'b1, 8'h11);
        rd(2'd0, 1'b0, 8'h0);
        rd(2'd0, 1'b1, 8'h22);
        rd(2'd1, 1'b0, 8'h0);
        rd(2'd0, 1'b0, 8'h0);

        // Mid-operation reset discards contents, overflow and mask
        for (int i = 0; i < 9; i++) idle(1'b1, 8'hA0 + 8'(i));
        for (int i = 0; i < 5; i++) rd(2'd0, 1'b0, 8'h0);
        wr(2'd2, 32'h1, 1'b0, 8'h0);
        rd(2'd1, 1'b0, 8'h0);
        rst_rd(2'd1);
        idle(1'b0, 8'h0);
        rd(2'd1, 1'b0, 8'h0);
        rd(2'd2, 1'b0, 8'h0);
        idle(1'b1, 8'hAA);
        rd(2'd0, 1'b0, 8'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit         iv;
            logic [7:0] id;
            iv = ($urandom_range(0, 99) < 55);
            id = 8'($urandom);
            r  = $urandom_range(0, 99);
            if (r < 30) begin
                rd(2'd0, iv, id);
            end else if (r < 42) begin
                rd(2'($urandom_range(0, 3)), iv, id);
            end else if (r < 47) begin
                wd    = $urandom;
                wd[0] = ($urandom_range(0, 7) == 0);
                wr(2'd1, wd, iv, id);
            end else if (r < 51) begin
                wr(2'd2, $urandom, iv, id);
            end else if (r < 53) begin
                wr(2'($urandom_range(0, 3)), $urandom & 32'hFFFF_FBFE, iv, id);
            end else if (r < 54) begin
                rst_rd(2'($urandom_range(0, 3)));
            end else begin
                idle(iv, id);
            end
        end

        idle(1'b0, 8'h0);
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
